// File: rtl/ldst_mem_bridge_pkg.sv
// rtl/ldst_mem_bridge_pkg.sv - shared widths and FSM encoding for the load/store memory bridge
package ldst_mem_bridge_pkg;

  localparam int ADDR_W = 16;
  localparam int OPR_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/ldst_mem_bridge_if.sv
// rtl/ldst_mem_bridge_if.sv - core load/store port and data-memory port bundle
interface ldst_mem_bridge_if
  import ldst_mem_bridge_pkg::*;
#(
  parameter int ADDR  = ADDR_W,
  parameter int W_OPR = OPR_W
);

  logic             core_req_i;
  logic             core_write_i;
  logic [ADDR-1:0]  core_addr_i;
  logic [W_OPR-1:0] core_data_i;
  logic [W_OPR-1:0] core_data_o;
  logic             stall_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [ADDR-1:0]  mem_addr_o;
  logic [W_OPR-1:0] mem_wdata_o;
  logic [W_OPR-1:0] mem_rdata_i;
  logic             mem_ack_i;
  logic             idle_o;
  logic             err_o;

  modport slave (
    input  core_req_i, core_write_i, core_addr_i, core_data_i, mem_rdata_i, mem_ack_i,
    output core_data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, idle_o, err_o
  );

  modport master (
    output core_req_i, core_write_i, core_addr_i, core_data_i, mem_rdata_i, mem_ack_i,
    input  core_data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, idle_o, err_o
  );

endinterface

// File: rtl/ldst_store_buffer.sv
// rtl/ldst_store_buffer.sv - one-entry posted-store buffer with load forwarding
module ldst_store_buffer
  import ldst_mem_bridge_pkg::*;
#(
  parameter int ADDR  = ADDR_W,
  parameter int W_OPR = OPR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             clear,
  input  logic             lookup,
  input  logic [ADDR-1:0]  req_addr,
  input  logic [W_OPR-1:0] req_data,
  output logic             valid,
  output logic [ADDR-1:0]  addr,
  output logic [W_OPR-1:0] data,
  output logic             hit,
  output logic [W_OPR-1:0] fwd_data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      addr  <= req_addr;
      data  <= req_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign hit      = lookup & valid & (req_addr == addr);
  assign fwd_data = hit ? data : '0;

endmodule

// File: rtl/ldst_mem_bridge.sv
// rtl/ldst_mem_bridge.sv - data-side bridge from core load/store port to a req/ack data memory
module ldst_mem_bridge
  import ldst_mem_bridge_pkg::*;
#(
  parameter int ADDR    = ADDR_W,
  parameter int W_OPR   = OPR_W,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  ldst_mem_bridge_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [W_OPR-1:0] rdata_q;
  logic             err_q;
  logic             mem_req_q, mem_we_q;
  logic [ADDR-1:0]  mem_addr_q;
  logic [W_OPR-1:0] mem_wdata_q;

  logic             wb_valid, hit, capture, clear, busy, expire, done, stall;
  logic [ADDR-1:0]  wb_addr;
  logic [W_OPR-1:0] wb_data, fwd_data;
  logic             is_load, is_store;

  assign is_load  = bus.core_req_i & ~bus.core_write_i;
  assign is_store = bus.core_req_i &  bus.core_write_i;
  assign busy     = (state == ST_DRAIN) | (state == ST_LOAD);
  // An ack on the final counted cycle still wins over the timeout.
  assign expire   = busy & ~bus.mem_ack_i & (cnt == CNT_W'(TIMEOUT - 1));
  assign done     = busy & (bus.mem_ack_i | expire);
  assign capture  = (state == ST_IDLE) & is_store & ~wb_valid;
  assign clear    = (state == ST_DRAIN) & done;

  ldst_store_buffer #(.ADDR(ADDR), .W_OPR(W_OPR)) u_wb (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .clear    (clear),
    .lookup   (is_load & ((state == ST_IDLE) | (state == ST_DRAIN))),
    .req_addr (bus.core_addr_i),
    .req_data (bus.core_data_i),
    .valid    (wb_valid),
    .addr     (wb_addr),
    .data     (wb_data),
    .hit      (hit),
    .fwd_data (fwd_data)
  );

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = (is_store & wb_valid) | (is_load & ~hit);
        if (wb_valid | capture)  state_n = ST_DRAIN;
        else if (is_load & ~hit) state_n = ST_LOAD;
      end
      ST_DRAIN: begin
        stall = bus.core_req_i & ~hit;
        if (done) state_n = ST_IDLE;
      end
      ST_LOAD: begin
        stall = 1'b1;
        if (done) state_n = ST_RESP;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= (busy && state_n == state) ? cnt + CNT_W'(1) : '0;
      if (state == ST_LOAD && done)
        rdata_q <= bus.mem_ack_i ? bus.mem_rdata_i : '0;
      if (expire)
        err_q <= 1'b1;
      mem_req_q <= (state_n == ST_DRAIN) | (state_n == ST_LOAD);
      mem_we_q  <= (state_n == ST_DRAIN);
      if (state_n == ST_DRAIN) begin
        mem_addr_q  <= capture ? bus.core_addr_i : wb_addr;
        mem_wdata_q <= capture ? bus.core_data_i : wb_data;
      end else if (state_n == ST_LOAD) begin
        mem_addr_q  <= bus.core_addr_i;
        mem_wdata_q <= '0;
      end else begin
        mem_addr_q  <= '0;
        mem_wdata_q <= '0;
      end
    end
  end

  assign bus.core_data_o = (state == ST_RESP) ? rdata_q : fwd_data;
  assign bus.stall_o     = stall;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.idle_o      = (state == ST_IDLE) & ~wb_valid;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_ldst_mem_bridge.sv
// tb/tb_ldst_mem_bridge.sv - directed cycle-vector bench for ldst_mem_bridge
module tb_ldst_mem_bridge;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  ldst_mem_bridge_if #(.ADDR(16), .W_OPR(32)) bus ();

  ldst_mem_bridge #(.ADDR(16), .W_OPR(32), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        req, wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rd;
    logic        stall;
    logic [31:0] data;
    logic        mreq, mwe;
    logic [15:0] maddr;
    logic [31:0] mwd;
    logic        idle;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic req, logic wr, logic [15:0] addr, logic [31:0] wd,
                              logic ack, logic [31:0] rd, logic stall, logic [31:0] data,
                              logic mreq, logic mwe, logic [15:0] maddr, logic [31:0] mwd,
                              logic idle);
    vec_t v;
    v.req = req; v.wr = wr; v.addr = addr; v.wd = wd; v.ack = ack; v.rd = rd;
    v.stall = stall; v.data = data; v.mreq = mreq; v.mwe = mwe;
    v.maddr = maddr; v.mwd = mwd; v.idle = idle;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wd, input logic ack, input logic [31:0] rd);
    bus.core_req_i   = req;
    bus.core_write_i = wr;
    bus.core_addr_i  = addr;
    bus.core_data_i  = wd;
    bus.mem_ack_i    = ack;
    bus.mem_rdata_i  = rd;
  endtask

  task automatic apply(input logic req, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wd, input logic ack, input logic [31:0] rd);
    drive(req, wr, addr, wd, ack, rd);
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // store 0x10, ack on third DRAIN cycle
    vecs[0]  = mk(1,1,16'h0010,32'hCAFEBABE,0,0, 0,0, 0,0,16'h0000,32'h0,        1);
    vecs[1]  = mk(0,0,16'h0000,32'h0,       0,0, 0,0, 1,1,16'h0010,32'hCAFEBABE, 0);
    vecs[2]  = mk(0,0,16'h0000,32'h0,       0,0, 0,0, 1,1,16'h0010,32'hCAFEBABE, 0);
    vecs[3]  = mk(0,0,16'h0000,32'h0,       1,0, 0,0, 1,1,16'h0010,32'hCAFEBABE, 0);
    vecs[4]  = mk(0,0,16'h0000,32'h0,       0,0, 0,0, 0,0,16'h0000,32'h0,        1);
    // store then forwarded load
    vecs[5]  = mk(1,1,16'h0020,32'h11111111,0,0, 0,0,           0,0,16'h0000,32'h0,        1);
    vecs[6]  = mk(1,0,16'h0020,32'h0,       0,0, 0,32'h11111111,1,1,16'h0020,32'h11111111, 0);
    vecs[7]  = mk(0,0,16'h0000,32'h0,       1,0, 0,0,           1,1,16'h0020,32'h11111111, 0);
    vecs[8]  = mk(0,0,16'h0000,32'h0,       0,0, 0,0,           0,0,16'h0000,32'h0,        1);
    // back-to-back stores, ack delay 3 lands on the timeout cycle
    vecs[9]  = mk(1,1,16'h0030,32'hA0A0A0A0,0,0, 0,0, 0,0,16'h0000,32'h0,        1);
    vecs[10] = mk(1,1,16'h0034,32'hB4B4B4B4,0,0, 1,0, 1,1,16'h0030,32'hA0A0A0A0, 0);
    vecs[11] = mk(1,1,16'h0034,32'hB4B4B4B4,0,0, 1,0, 1,1,16'h0030,32'hA0A0A0A0, 0);
    vecs[12] = mk(1,1,16'h0034,32'hB4B4B4B4,0,0, 1,0, 1,1,16'h0030,32'hA0A0A0A0, 0);
    vecs[13] = mk(1,1,16'h0034,32'hB4B4B4B4,1,0, 1,0, 1,1,16'h0030,32'hA0A0A0A0, 0);
    vecs[14] = mk(1,1,16'h0034,32'hB4B4B4B4,0,0, 0,0, 0,0,16'h0000,32'h0,        1);
    vecs[15] = mk(0,0,16'h0000,32'h0,       0,0, 0,0, 1,1,16'h0034,32'hB4B4B4B4, 0);
    vecs[16] = mk(0,0,16'h0000,32'h0,       1,0, 0,0, 1,1,16'h0034,32'hB4B4B4B4, 0);
    vecs[17] = mk(0,0,16'h0000,32'h0,       0,0, 0,0, 0,0,16'h0000,32'h0,        1);
    // zero-wait load miss
    vecs[18] = mk(1,0,16'h0040,32'h0,1'b0,32'h0,        1,0,           0,0,16'h0000,32'h0, 1);
    vecs[19] = mk(1,0,16'h0040,32'h0,1'b1,32'h12345678, 1,0,           1,0,16'h0040,32'h0, 0);
    vecs[20] = mk(1,0,16'h0040,32'h0,1'b0,32'h0,        0,32'h12345678,0,0,16'h0000,32'h0, 0);
    vecs[21] = mk(0,0,16'h0000,32'h0,1'b0,32'h0,        0,0,           0,0,16'h0000,32'h0, 1);

    rst_n = 1'b0;
    drive(0, 0, 16'h0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_idle",  0, 32'(bus.idle_o),      32'd1);
    chk("rst_stall", 0, 32'(bus.stall_o),     32'd0);
    chk("rst_mreq",  0, 32'(bus.mem_req_o),   32'd0);
    chk("rst_maddr", 0, 32'(bus.mem_addr_o),  32'd0);
    chk("rst_err",   0, 32'(bus.err_o),       32'd0);
    chk("rst_data",  0, bus.core_data_o,      32'd0);
    rst_n = 1'b1;
    adv();

    for (int i = 0; i < 22; i++) begin
      apply(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].ack, vecs[i].rd);
      chk("stall", i, 32'(bus.stall_o),    32'(vecs[i].stall));
      chk("data",  i, bus.core_data_o,     vecs[i].data);
      chk("mreq",  i, 32'(bus.mem_req_o),  32'(vecs[i].mreq));
      chk("mwe",   i, 32'(bus.mem_we_o),   32'(vecs[i].mwe));
      chk("maddr", i, 32'(bus.mem_addr_o), 32'(vecs[i].maddr));
      chk("mwd",   i, bus.mem_wdata_o,     vecs[i].mwd);
      chk("idle",  i, 32'(bus.idle_o),     32'(vecs[i].idle));
      chk("err",   i, 32'(bus.err_o),      32'd0);
      adv();
    end

    // dead memory: four LOAD cycles then RESP with zero data and sticky error
    apply(1, 0, 16'h0050, 32'h0, 0, 32'h0);
    chk("to_req_stall", 0, 32'(bus.stall_o),   32'd1);
    chk("to_req_mreq",  0, 32'(bus.mem_req_o), 32'd0);
    adv();
    for (int k = 0; k < 4; k++) begin
      apply(1, 0, 16'h0050, 32'h0, 0, 32'h0);
      chk("to_load_mreq",  k, 32'(bus.mem_req_o),  32'd1);
      chk("to_load_maddr", k, 32'(bus.mem_addr_o), 32'h0050);
      chk("to_load_stall", k, 32'(bus.stall_o),    32'd1);
      chk("to_load_err",   k, 32'(bus.err_o),      32'd0);
      adv();
    end
    apply(1, 0, 16'h0050, 32'h0, 0, 32'h0);
    chk("to_resp_stall", 0, 32'(bus.stall_o),   32'd0);
    chk("to_resp_data",  0, bus.core_data_o,    32'd0);
    chk("to_resp_mreq",  0, 32'(bus.mem_req_o), 32'd0);
    chk("to_resp_err",   0, 32'(bus.err_o),     32'd1);
    adv();
    apply(0, 0, 16'h0, 32'h0, 0, 32'h0);
    chk("to_after_idle", 0, 32'(bus.idle_o), 32'd1);
    chk("to_after_err",  0, 32'(bus.err_o),  32'd1);
    adv();

    // async reset in the middle of a LOAD
    apply(1, 0, 16'h0060, 32'h0, 0, 32'h0);
    chk("rl_stall", 0, 32'(bus.stall_o), 32'd1);
    adv();
    apply(1, 0, 16'h0060, 32'h0, 0, 32'h0);
    chk("rl_mreq", 0, 32'(bus.mem_req_o), 32'd1);
    drive(0, 0, 16'h0, 32'h0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rl_mreq_drop", 0, 32'(bus.mem_req_o), 32'd0);
    chk("rl_idle",      0, 32'(bus.idle_o),    32'd1);
    chk("rl_err_clr",   0, 32'(bus.err_o),     32'd0);
    adv();
    rst_n = 1'b1;
    apply(0, 0, 16'h0, 32'h0, 1, 32'hDEADBEEF);
    chk("rl_late_mreq", 0, 32'(bus.mem_req_o), 32'd0);
    chk("rl_late_data", 0, bus.core_data_o,    32'd0);
    adv();
    apply(0, 0, 16'h0, 32'h0, 0, 32'h0);
    chk("rl_final_idle", 0, 32'(bus.idle_o),    32'd1);
    chk("rl_final_mreq", 0, 32'(bus.mem_req_o), 32'd0);
    chk("rl_final_err",  0, 32'(bus.err_o),     32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
